// File: rtl/crc_engine_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : crc_engine_arbiter
//  Purpose  : Round-robin sharing of one byte-wide CRC16 engine between NREQ
//             word requesters; streams each word MSB byte first.
//  Revision : 1.0  initial release
// ============================================================================
module crc_engine_arbiter #(
  parameter int NREQ   = 4,
  parameter int DATA_W = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*DATA_W-1:0]   reqData,
  output logic [NREQ-1:0]          grant,
  output logic [NREQ-1:0]          done,
  output logic [15:0]              crcResult,
  output logic                     busy,
  output logic [7:0]               engData,
  output logic                     engEn,
  output logic                     engRst,
  input  logic [15:0]              engCrc
);

  localparam int NBYTE = DATA_W / 8;
  localparam int IDX_W = $clog2(NREQ);
  localparam int CNT_W = (NBYTE > 1) ? $clog2(NBYTE) : 1;
  localparam logic [CNT_W-1:0] C_LAST_BYTE = CNT_W'(NBYTE - 1);
  localparam logic [IDX_W-1:0] C_LAST_REQ  = IDX_W'(NREQ - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CLR  = 3'd1,
    S_FEED = 3'd2,
    S_WAIT = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t             r_state;
  logic [IDX_W-1:0]   r_rrPtr;
  logic [CNT_W-1:0]   r_cnt;
  logic [DATA_W-1:0]  r_capture;

  logic               w_pickValid;
  logic [IDX_W-1:0]   w_pickIdx;
  logic [NREQ-1:0]    w_pickOneHot;
  logic [DATA_W-1:0]  w_pickData;
  logic [CNT_W-1:0]   w_byteIdx;
  logic [7:0]         w_byte;

  // Scan from farthest to nearest so the requester just after rrPtr wins.
  always_comb begin
    w_pickValid = 1'b0;
    w_pickIdx   = '0;
    for (int k = NREQ; k >= 1; k--) begin
      logic [IDX_W-1:0] cand;
      cand = IDX_W'((int'(r_rrPtr) + k) % NREQ);
      if (req[cand]) begin
        w_pickValid = 1'b1;
        w_pickIdx   = cand;
      end
    end
  end

  always_comb begin
    w_pickOneHot = NREQ'(1) << w_pickIdx;
    w_pickData   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_pickIdx == IDX_W'(i)) begin
        w_pickData = reqData[i*DATA_W +: DATA_W];
      end
    end
  end

  // Byte to present on the next cycle: byte 0 leaving CLR, else the successor.
  always_comb begin
    w_byteIdx = (r_state == S_FEED) ? r_cnt + 1'b1 : '0;
    w_byte    = '0;
    for (int b = 0; b < NBYTE; b++) begin
      if (w_byteIdx == CNT_W'(b)) begin
        w_byte = r_capture[DATA_W-1-8*b -: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_rrPtr   <= C_LAST_REQ;
      r_cnt     <= '0;
      r_capture <= '0;
      grant     <= '0;
      done      <= '0;
      crcResult <= '0;
      busy      <= 1'b0;
      engData   <= '0;
      engEn     <= 1'b0;
      engRst    <= 1'b0;
    end else begin
      engRst  <= 1'b0;
      engEn   <= 1'b0;
      engData <= '0;
      done    <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_pickValid) begin
            r_capture <= w_pickData;
            grant     <= w_pickOneHot;
            r_rrPtr   <= w_pickIdx;
            engRst    <= 1'b1;
            busy      <= 1'b1;
            r_state   <= S_CLR;
          end
        end
        S_CLR: begin
          engEn   <= 1'b1;
          engData <= w_byte;
          r_cnt   <= '0;
          r_state <= S_FEED;
        end
        S_FEED: begin
          if (r_cnt == C_LAST_BYTE) begin
            r_cnt   <= '0;
            r_state <= S_WAIT;
          end else begin
            r_cnt   <= r_cnt + 1'b1;
            engEn   <= 1'b1;
            engData <= w_byte;
          end
        end
        S_WAIT: begin
          crcResult <= engCrc;
          done      <= grant;
          r_state   <= S_DONE;
        end
        S_DONE: begin
          grant   <= '0;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          grant   <= '0;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_crc_engine_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_crc_engine_arbiter
//  Purpose  : Self-checking bench for crc_engine_arbiter with a CRC16 engine model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_crc_engine_arbiter;
  localparam int NREQ = 4;
  localparam int DATA_W = 64;
  localparam int NBYTE = 8;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NREQ-1:0]        req;
  logic [NREQ*DATA_W-1:0] reqData;
  logic [NREQ-1:0]        grant, done;
  logic [15:0]            crcResult, engCrc;
  logic                   busy, engEn, engRst;
  logic [7:0]             engData;

  crc_engine_arbiter #(.NREQ(NREQ), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .req(req), .reqData(reqData), .grant(grant), .done(done),
    .crcResult(crcResult), .busy(busy), .engData(engData), .engEn(engEn),
    .engRst(engRst), .engCrc(engCrc)
  );

  always #5 clk = ~clk;

  // CCITT CRC16 engine model, init 0xFFFF on clear
  function automatic logic [15:0] crcStep(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c ^ {d, 8'h00};
    for (int i = 0; i < 8; i++) r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
    return r;
  endfunction

  function automatic logic [15:0] crcWord(input logic [63:0] w);
    logic [15:0] c;
    logic [63:0] t;
    c = 16'hFFFF;
    for (int k = 0; k < NBYTE; k++) begin
      t = w << (8 * k);
      c = crcStep(c, t[63:56]);
    end
    return c;
  endfunction

  logic [15:0] engReg = 16'h0000;
  logic        engFixed = 1'b0;
  always @(posedge clk) begin
    if (engRst) engReg <= 16'hFFFF;
    else if (engEn) engReg <= crcStep(engReg, engData);
  end
  assign engCrc = engFixed ? 16'hBEEF : engReg;

  typedef struct packed {
    logic [NREQ-1:0] g;
    logic [15:0]     crc;
  } done_t;

  done_t       expDone[$];
  logic [7:0]  expBytes[$];
  int          passCnt = 0;
  int          totalCnt = 0;
  done_t       dPop;
  logic [7:0]  bPop;

  task automatic pushOp(input int idx, input logic [63:0] w);
    logic [63:0] t;
    done_t d;
    for (int k = 0; k < NBYTE; k++) begin
      t = w << (8 * k);
      expBytes.push_back(t[63:56]);
    end
    d.g = 4'(1) << idx;
    d.crc = engFixed ? 16'hBEEF : crcWord(w);
    expDone.push_back(d);
  endtask

  task automatic setData(input int idx, input logic [63:0] w);
    reqData[idx*DATA_W +: DATA_W] = w;
  endtask

  // Scoreboard side: every fed byte and every done pulse is popped and compared.
  always @(negedge clk) begin
    if (engEn === 1'b1) begin
      totalCnt++;
      if (expBytes.size() == 0) $display("FAIL engData_unexpected: got %h want none", engData);
      else begin
        bPop = expBytes.pop_front();
        if (engData !== bPop) $display("FAIL engData: got %h want %h", engData, bPop);
        else passCnt++;
      end
    end else if (engEn === 1'b0) begin
      totalCnt++;
      if (engData !== 8'h00) $display("FAIL engData_idle: got %h want 00", engData);
      else passCnt++;
    end
    if (|done === 1'b1) begin
      totalCnt++;
      if (expDone.size() == 0) $display("FAIL done_unexpected: got %b want none", done);
      else begin
        dPop = expDone.pop_front();
        if (done !== dPop.g || crcResult !== dPop.crc || grant !== dPop.g)
          $display("FAIL done_result: got done=%b grant=%b crc=%h want done=%b crc=%h",
                   done, grant, crcResult, dPop.g, dPop.crc);
        else passCnt++;
      end
    end
  end

  task automatic test_reset;
    rst = 1'b1; req = '0; reqData = '0;
    repeat (3) @(negedge clk);
    totalCnt++;
    if ({grant, done, crcResult, busy, engData, engEn, engRst} !== '0)
      $display("FAIL reset_outputs: got grant=%b done=%b crc=%h busy=%b data=%h en=%b rst=%b want all 0",
               grant, done, crcResult, busy, engData, engEn, engRst);
    else passCnt++;
    rst = 1'b0;
  endtask

  task automatic test_single;
    logic [NREQ-1:0] eg, ed;
    engFixed = 1'b1;
    setData(0, 64'h0123456789ABCDEF);
    pushOp(0, 64'h0123456789ABCDEF);
    req = 4'b0001;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 1) req = '0;
      eg = (c <= 11) ? 4'b0001 : 4'b0000;
      ed = (c == 11) ? 4'b0001 : 4'b0000;
      totalCnt++;
      if (grant !== eg) $display("FAIL single_grant c%0d: got %b want %b", c, grant, eg); else passCnt++;
      totalCnt++;
      if (engRst !== (c == 1)) $display("FAIL single_engRst c%0d: got %b want %b", c, engRst, c == 1); else passCnt++;
      totalCnt++;
      if (engEn !== (c >= 2 && c <= 9)) $display("FAIL single_engEn c%0d: got %b", c, engEn); else passCnt++;
      totalCnt++;
      if (busy !== (c <= 11)) $display("FAIL single_busy c%0d: got %b want %b", c, busy, c <= 11); else passCnt++;
      totalCnt++;
      if (done !== ed) $display("FAIL single_done c%0d: got %b want %b", c, done, ed); else passCnt++;
    end
    totalCnt++;
    if (crcResult !== 16'hBEEF) $display("FAIL single_crcHold: got %h want beef", crcResult); else passCnt++;
    engFixed = 1'b0;
  endtask

  task automatic test_pulse_ff;
    int nEn = 0;
    setData(1, 64'hFFFF_FFFF_FFFF_FFFF);
    pushOp(1, 64'hFFFF_FFFF_FFFF_FFFF);
    req = 4'b0010;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 1) begin
        req = '0;
        totalCnt++;
        if (grant !== 4'b0010) $display("FAIL pulse_grant: got %b want 0010", grant); else passCnt++;
      end
      if (engEn === 1'b1) nEn++;
      if (c == 11) begin
        totalCnt++;
        if (done !== 4'b0010) $display("FAIL pulse_done: got %b want 0010", done); else passCnt++;
      end
    end
    totalCnt++;
    if (nEn != 8) $display("FAIL pulse_bytes: got %0d want 8", nEn); else passCnt++;
  endtask

  task automatic test_data_change;
    setData(0, 64'h1122334455667788);
    pushOp(0, 64'h1122334455667788);
    req = 4'b0001;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 1) begin
        req = '0;
        totalCnt++;
        if (grant !== 4'b0001) $display("FAIL change_grant: got %b want 0001", grant); else passCnt++;
      end
      if (c == 4) setData(0, 64'hDEAD_BEEF_0BAD_F00D);
      if (c == 11) begin
        totalCnt++;
        if (done !== 4'b0001) $display("FAIL change_done: got %b want 0001", done); else passCnt++;
      end
    end
  endtask

  // Expects back-to-back operations, one every 12 cycles, in the given order.
  task automatic test_round_robin;
    int order[5] = '{0, 1, 2, 3, 0};
    int op, ph;
    logic [NREQ-1:0] eg, ed;
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    setData(0, 64'hA0A1A2A3A4A5A6A7); setData(1, 64'hB0B1B2B3B4B5B6B7);
    setData(2, 64'hC0C1C2C3C4C5C6C7); setData(3, 64'hD0D1D2D3D4D5D6D7);
    for (int n = 0; n < 5; n++) pushOp(order[n], reqData[order[n]*DATA_W +: DATA_W]);
    req = 4'b1111;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (c == 49) req = '0;
      op = (c - 1) / 12; ph = (c - 1) % 12;
      eg = (ph <= 10) ? 4'(4'(1) << order[op]) : 4'b0000;
      ed = (ph == 10) ? eg : 4'b0000;
      totalCnt++;
      if (grant !== eg || done !== ed)
        $display("FAIL rr_grant c%0d: got grant=%b done=%b want grant=%b done=%b", c, grant, done, eg, ed);
      else passCnt++;
    end
  endtask

  task automatic test_priority;
    int order[3] = '{2, 3, 0};
    int op, ph;
    logic [NREQ-1:0] eg;
    setData(2, 64'h2222_0000_1111_3333); setData(3, 64'h3333_4444_5555_6666);
    setData(0, 64'h0F0F_F0F0_1234_5678);
    for (int n = 0; n < 3; n++) pushOp(order[n], reqData[order[n]*DATA_W +: DATA_W]);
    req = 4'b0100;
    for (int c = 1; c <= 36; c++) begin
      @(negedge clk);
      if (c == 1) req = 4'b1001;
      if (c == 25) req = '0;
      op = (c - 1) / 12; ph = (c - 1) % 12;
      eg = (ph <= 10) ? 4'(4'(1) << order[op]) : 4'b0000;
      totalCnt++;
      if (grant !== eg) $display("FAIL prio_grant c%0d: got %b want %b", c, grant, eg); else passCnt++;
    end
  endtask

  task automatic test_reset_mid;
    logic [63:0] t;
    setData(0, 64'h0102030405060708);
    for (int k = 0; k < 4; k++) begin
      t = 64'h0102030405060708 << (8 * k);
      expBytes.push_back(t[63:56]);
    end
    req = 4'b0001;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 1) req = '0;
    end
    rst = 1'b1;
    @(negedge clk);
    totalCnt++;
    if ({grant, done, crcResult, busy, engEn, engRst} !== '0)
      $display("FAIL rstmid_outputs: got grant=%b done=%b crc=%h busy=%b en=%b rst=%b want all 0",
               grant, done, crcResult, busy, engEn, engRst);
    else passCnt++;
    rst = 1'b0;
    setData(1, 64'h5A5A_A5A5_3C3C_C3C3);
    pushOp(1, 64'h5A5A_A5A5_3C3C_C3C3);
    req = 4'b0010;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 1) req = '0;
      totalCnt++;
      if (grant !== ((c <= 11) ? 4'b0010 : 4'b0000))
        $display("FAIL rstmid_grant c%0d: got %b", c, grant);
      else passCnt++;
      totalCnt++;
      if (done !== ((c == 11) ? 4'b0010 : 4'b0000)) $display("FAIL rstmid_done c%0d: got %b", c, done);
      else passCnt++;
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_pulse_ff;
    test_data_change;
    test_round_robin;
    test_priority;
    test_reset_mid;
    for (int k = 0; k < 40 && (expBytes.size() != 0 || expDone.size() != 0); k++) @(negedge clk);
    totalCnt++;
    if (expBytes.size() != 0 || expDone.size() != 0)
      $display("FAIL scoreboard_drain: got bytes=%0d dones=%0d want 0 0", expBytes.size(), expDone.size());
    else passCnt++;
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
`default_nettype wire
